// File: rtl/sram_march_bist_ctrl_if.sv
// BIST port bundle between the March C- controller (master) and the SRAM macro (slave).
// Latency: none, plain wires; all controller-side outputs are registered in the controller.
// Backpressure: none, the macro accepts one operation per A_BIST_CLK cycle.
interface sram_march_bist_ctrl_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 64
);
  logic              A_BIST_EN;
  logic              A_BIST_MEN;
  logic              A_BIST_WEN;
  logic              A_BIST_REN;
  logic [ADDR_W-1:0] A_BIST_ADDR;
  logic [DATA_W-1:0] A_BIST_DIN;
  logic [DATA_W-1:0] A_BIST_BM;
  logic [DATA_W-1:0] A_DOUT;

  modport master (
    output A_BIST_EN, A_BIST_MEN, A_BIST_WEN, A_BIST_REN,
    output A_BIST_ADDR, A_BIST_DIN, A_BIST_BM,
    input  A_DOUT
  );

  modport slave (
    input  A_BIST_EN, A_BIST_MEN, A_BIST_WEN, A_BIST_REN,
    input  A_BIST_ADDR, A_BIST_DIN, A_BIST_BM,
    output A_DOUT
  );
endinterface

// File: rtl/sram_march_bist_ctrl.sv
// March C- BIST controller for the 64x64 single-port SRAM BIST port; BIST_DIAG_EN adds first-fail diagnostics.
// Latency: one macro op per cycle starting the cycle after START; DONE rises RD_LAT cycles after the last op.
// Backpressure: none; the macro takes an op every cycle and START is ignored while BUSY.
module sram_march_bist_ctrl #(
  parameter int                ADDR_W  = 6,
  parameter int                DATA_W  = 64,
  parameter int                RD_LAT  = 1,
  parameter logic [DATA_W-1:0] DATA_BG = {DATA_W{1'b0}}
) (
  input  logic                   A_BIST_CLK,
  input  logic                   A_BIST_RST,
  input  logic                   START,
  sram_march_bist_ctrl_if.master bist,
  output logic                   BUSY,
  output logic                   DONE,
  output logic                   FAIL,
  output logic [ADDR_W-1:0]      FAIL_ADDR,
  output logic [2:0]             FAIL_ELEM,
  output logic [15:0]            FAIL_CNT
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_FINISH} state_t;

  // One in-flight read awaiting its A_DOUT compare.
  typedef struct packed {
    logic              vld;
    logic [DATA_W-1:0] exp;
`ifdef BIST_DIAG_EN
    logic [ADDR_W-1:0] addr;
    logic [2:0]        elem;
`endif
  } cmp_t;

  // M1..M4 are read-then-write elements (two ops per address).
  function automatic logic elem_two_op(input logic [2:0] e);
    return (e >= 3'd1) && (e <= 3'd4);
  endfunction

  // M0 is write-only, M5 read-only, M1..M4 read on their first phase.
  function automatic logic op_is_read(input logic [2:0] e, input logic ph);
    if (e == 3'd0) return 1'b0;
    if (e == 3'd5) return 1'b1;
    return !ph;
  endfunction

  // Reads expect "1" in M2 and M4; writes store "1" in M1 and M3.
  function automatic logic read_val(input logic [2:0] e);
    return (e == 3'd2) || (e == 3'd4);
  endfunction

  function automatic logic write_val(input logic [2:0] e);
    return (e == 3'd1) || (e == 3'd3);
  endfunction

  function automatic logic [DATA_W-1:0] pattern(input logic v);
    return v ? ~DATA_BG : DATA_BG;
  endfunction

  // M3..M5 walk downwards; inverting the index gives top-to-bottom order.
  function automatic logic [ADDR_W-1:0] addr_of(input logic [2:0] e, input logic [ADDR_W-1:0] idx);
    return (e >= 3'd3) ? ~idx : idx;
  endfunction

  state_t            state_q, state_d;
  logic [2:0]        elem_q, elem_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              ph_q, ph_d;
  logic [1:0]        drain_q, drain_d;
  logic              start_clr;

  logic              en_q, en_d;
  logic              men_q, men_d;
  logic              wen_q, wen_d;
  logic              ren_q, ren_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic [DATA_W-1:0] bm_q, bm_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              fail_q, fail_d;

  cmp_t              pipe_q [RD_LAT];
  cmp_t              pipe_d [RD_LAT];
  cmp_t              head;
  logic              miscmp;

`ifdef BIST_DIAG_EN
  logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
  logic [2:0]        fail_elem_q, fail_elem_d;
  logic [15:0]       fail_cnt_q, fail_cnt_d;
`endif

  // Sequencer: walks M0..M5 one op per cycle, then drains the compare pipe.
  always_comb begin
    state_d   = state_q;
    elem_d    = elem_q;
    idx_d     = idx_q;
    ph_d      = ph_q;
    drain_d   = drain_q;
    done_d    = done_q;
    start_clr = 1'b0;
    case (state_q)
      S_IDLE, S_FINISH: begin
        if (START) begin
          state_d   = S_RUN;
          elem_d    = 3'd0;
          idx_d     = '0;
          ph_d      = 1'b0;
          done_d    = 1'b0;
          start_clr = 1'b1;
        end
      end
      S_RUN: begin
        if (elem_two_op(elem_q) && !ph_q) begin
          ph_d = 1'b1;
        end else begin
          ph_d = 1'b0;
          if (idx_q == '1) begin
            idx_d = '0;
            if (elem_q == 3'd5) begin
              state_d = S_DRAIN;
              drain_d = 2'd0;
            end else begin
              elem_d = elem_q + 3'd1;
            end
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (drain_q == 2'(RD_LAT - 1)) begin
          state_d = S_FINISH;
          done_d  = 1'b1;
        end else begin
          drain_d = drain_q + 2'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Bus outputs are registered from the op the sequencer moves to.
    men_d  = (state_d == S_RUN);
    ren_d  = men_d && op_is_read(elem_d, ph_d);
    wen_d  = men_d && !op_is_read(elem_d, ph_d);
    addr_d = men_d ? addr_of(elem_d, idx_d) : '0;
    din_d  = wen_d ? pattern(write_val(elem_d)) : '0;
    bm_d   = wen_d ? '1 : '0;
    busy_d = (state_d == S_RUN) || (state_d == S_DRAIN);
    en_d   = busy_d;
  end

  assign head   = pipe_q[RD_LAT-1];
  assign miscmp = head.vld && (bist.A_DOUT != head.exp);

  // Compare pipe and sticky status: the read on the bus now is checked RD_LAT cycles later.
  always_comb begin
    pipe_d[0].vld = ren_q;
    pipe_d[0].exp = pattern(read_val(elem_q));
`ifdef BIST_DIAG_EN
    pipe_d[0].addr = addr_q;
    pipe_d[0].elem = elem_q;
`endif
    for (int i = 1; i < RD_LAT; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end

    fail_d = fail_q;
    if (start_clr)   fail_d = 1'b0;
    else if (miscmp) fail_d = 1'b1;

`ifdef BIST_DIAG_EN
    fail_addr_d = fail_addr_q;
    fail_elem_d = fail_elem_q;
    fail_cnt_d  = fail_cnt_q;
    if (start_clr) begin
      fail_addr_d = '0;
      fail_elem_d = '0;
      fail_cnt_d  = '0;
    end else if (miscmp) begin
      if (fail_cnt_q != 16'hFFFF) fail_cnt_d = fail_cnt_q + 16'd1;
      if (!fail_q) begin
        fail_addr_d = head.addr;
        fail_elem_d = head.elem;
      end
    end
`endif
  end

  // State, bus and status registers; reset aborts any run and drops pending compares.
  always_ff @(posedge A_BIST_CLK) begin
    if (A_BIST_RST) begin
      state_q <= S_IDLE;
      elem_q  <= '0;
      idx_q   <= '0;
      ph_q    <= 1'b0;
      drain_q <= '0;
      en_q    <= 1'b0;
      men_q   <= 1'b0;
      wen_q   <= 1'b0;
      ren_q   <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
      bm_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fail_q  <= 1'b0;
      for (int i = 0; i < RD_LAT; i++) pipe_q[i] <= '0;
`ifdef BIST_DIAG_EN
      fail_addr_q <= '0;
      fail_elem_q <= '0;
      fail_cnt_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      elem_q  <= elem_d;
      idx_q   <= idx_d;
      ph_q    <= ph_d;
      drain_q <= drain_d;
      en_q    <= en_d;
      men_q   <= men_d;
      wen_q   <= wen_d;
      ren_q   <= ren_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      bm_q    <= bm_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      fail_q  <= fail_d;
      for (int i = 0; i < RD_LAT; i++) pipe_q[i] <= pipe_d[i];
`ifdef BIST_DIAG_EN
      fail_addr_q <= fail_addr_d;
      fail_elem_q <= fail_elem_d;
      fail_cnt_q  <= fail_cnt_d;
`endif
    end
  end

  assign bist.A_BIST_EN   = en_q;
  assign bist.A_BIST_MEN  = men_q;
  assign bist.A_BIST_WEN  = wen_q;
  assign bist.A_BIST_REN  = ren_q;
  assign bist.A_BIST_ADDR = addr_q;
  assign bist.A_BIST_DIN  = din_q;
  assign bist.A_BIST_BM   = bm_q;
  assign BUSY             = busy_q;
  assign DONE             = done_q;
  assign FAIL             = fail_q;

`ifdef BIST_DIAG_EN
  assign FAIL_ADDR = fail_addr_q;
  assign FAIL_ELEM = fail_elem_q;
  assign FAIL_CNT  = fail_cnt_q;
`else
  assign FAIL_ADDR = '0;
  assign FAIL_ELEM = '0;
  assign FAIL_CNT  = '0;
`endif

endmodule

// File: tb/tb_sram_march_bist_ctrl.sv
// Bench for sram_march_bist_ctrl: behavioural SRAM with stuck-at faults plus a March C- reference.
// Latency checked: first op the cycle after START, DONE at cycle 641+RD_LAT.
// Backpressure: none; the bench macro answers every read after RD_LAT.
module tb_sram_march_bist_ctrl;
  localparam int          ADDR_W  = 6;
  localparam int          DATA_W  = 64;
  localparam int          RD_LAT  = 1;
  localparam int          WORDS   = 64;
  localparam int          NOPS    = 640;
  localparam logic [63:0] DATA_BG = 64'h0;
  localparam logic [63:0] ONES    = '1;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        busy, done, fail;
  logic [5:0]  fail_addr;
  logic [2:0]  fail_elem;
  logic [15:0] fail_cnt;

  always #5 clk = ~clk;

  sram_march_bist_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bif ();

  sram_march_bist_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .DATA_BG(DATA_BG)) dut (
    .A_BIST_CLK(clk),
    .A_BIST_RST(rst),
    .START     (start),
    .bist      (bif),
    .BUSY      (busy),
    .DONE      (done),
    .FAIL      (fail),
    .FAIL_ADDR (fail_addr),
    .FAIL_ELEM (fail_elem),
    .FAIL_CNT  (fail_cnt)
  );

  // Behavioural macro: masked writes, stuck-at faults applied on read, RD_LAT read pipe.
  logic [63:0] mem     [WORDS];
  logic [63:0] sa1     [WORDS];
  logic [63:0] sa0     [WORDS];
  logic [63:0] rd_pipe [RD_LAT];

  always @(posedge clk) begin
    if (bif.A_BIST_MEN && bif.A_BIST_WEN)
      mem[bif.A_BIST_ADDR] <= (mem[bif.A_BIST_ADDR] & ~bif.A_BIST_BM) | (bif.A_BIST_DIN & bif.A_BIST_BM);
    if (bif.A_BIST_MEN && bif.A_BIST_REN)
      rd_pipe[0] <= (mem[bif.A_BIST_ADDR] | sa1[bif.A_BIST_ADDR]) & ~sa0[bif.A_BIST_ADDR];
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign bif.A_DOUT = rd_pipe[RD_LAT-1];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual %0h required %0h", name, act, req);
    end
  endtask

  // Reference: expanded op list of March C- and the fail statistics it should produce.
  logic        exp_wen  [NOPS];
  logic [5:0]  exp_addr [NOPS];
  logic [63:0] exp_din  [NOPS];
  logic        m_fail;
  int          m_faddr, m_felem, m_fcnt;

  task automatic build_model();
    logic [63:0] mm [WORDS];
    int rv [6];
    int wv [6];
    int n;
    int a;
    logic [63:0] got, want;
    rv = '{-1, 0, 1, 0, 1, 0};
    wv = '{0, 1, 0, 1, 0, -1};
    n = 0;
    m_fail = 1'b0; m_faddr = 0; m_felem = 0; m_fcnt = 0;
    for (int e = 0; e < 6; e++) begin
      for (int k = 0; k < WORDS; k++) begin
        a = (e >= 3) ? (WORDS - 1 - k) : k;
        if (rv[e] >= 0) begin
          exp_wen[n] = 1'b0; exp_addr[n] = 6'(a); exp_din[n] = '0; n++;
          got  = (mm[a] | sa1[a]) & ~sa0[a];
          want = (rv[e] == 1) ? ~DATA_BG : DATA_BG;
          if (got != want) begin
            if (!m_fail) begin m_faddr = a; m_felem = e; end
            m_fail = 1'b1;
            m_fcnt++;
          end
        end
        if (wv[e] >= 0) begin
          mm[a] = (wv[e] == 1) ? ~DATA_BG : DATA_BG;
          exp_wen[n] = 1'b1; exp_addr[n] = 6'(a); exp_din[n] = mm[a]; n++;
        end
      end
    end
  endtask

  task automatic clear_faults();
    for (int i = 0; i < WORDS; i++) begin sa1[i] = '0; sa0[i] = '0; end
  endtask

  task automatic add_fault(input int a, input int b, input logic stuck1);
    if (stuck1) sa1[a][b] = 1'b1;
    else        sa0[a][b] = 1'b1;
  endtask

  // Pulses START in the current cycle (cycle 0) and follows the run to DONE.
  task automatic run_one(input int extra_at, input logic e_fail, input int e_addr, input int e_elem, input int e_cnt);
    int cyc, idx, terr, men_n, done_cyc;
    logic in_run;
    build_model();
    start = 1'b1;
    cyc = 0; idx = 0; terr = 0; men_n = 0; done_cyc = -1;
    while (cyc < 2000) begin
      @(negedge clk);
      cyc++;
      start = (cyc == extra_at);
      if (cyc == 1) check("start_clear", {61'd0, done, fail, busy}, 64'd1);
      if (bif.A_BIST_MEN) begin
        men_n++;
        if (idx >= NOPS) terr++;
        else if (bif.A_BIST_WEN !== exp_wen[idx] || bif.A_BIST_REN !== !exp_wen[idx] ||
                 bif.A_BIST_ADDR !== exp_addr[idx] || bif.A_BIST_BM !== (exp_wen[idx] ? ONES : 64'd0)) terr++;
        else if (exp_wen[idx] && bif.A_BIST_DIN !== exp_din[idx]) terr++;
        idx++;
      end else if (bif.A_BIST_WEN || bif.A_BIST_REN || bif.A_BIST_ADDR != 0 ||
                   bif.A_BIST_DIN != 0 || bif.A_BIST_BM != 0) terr++;
      if (done) begin done_cyc = cyc; break; end
      in_run = (cyc <= NOPS + RD_LAT);
      if (bif.A_BIST_EN !== in_run || busy !== in_run) terr++;
    end
    check("done_cycle", done_cyc, 641 + RD_LAT);
    check("men_cycles", men_n, NOPS);
    check("trace_mismatch", terr, 0);
    check("idle_after_done", {61'd0, busy, bif.A_BIST_EN, bif.A_BIST_MEN}, 64'd0);
    check("fail_flag", fail, e_fail);
`ifdef BIST_DIAG_EN
    check("fail_addr", fail_addr, e_addr);
    check("fail_elem", fail_elem, e_elem);
    check("fail_cnt", fail_cnt, e_cnt);
`else
    check("fail_addr_tied", fail_addr, 0);
    check("fail_elem_tied", fail_elem, 0);
    check("fail_cnt_tied", fail_cnt, 0);
`endif
  endtask

  typedef struct {
    int   nf;
    int   fa [2];
    int   fb [2];
    logic f1 [2];
    logic e_fail;
    int   e_addr;
    int   e_elem;
    int   e_cnt;
  } vec_t;

  vec_t tbl [6];

  initial begin
    int nf, xs, cyc;
    tbl[0] = '{0, '{0, 0},   '{0, 0},  '{0, 0}, 1'b0, 0,  0, 0};
    tbl[1] = '{1, '{5, 0},   '{3, 0},  '{1, 0}, 1'b1, 5,  1, 3};
    tbl[2] = '{1, '{0, 0},   '{0, 0},  '{0, 0}, 1'b1, 0,  2, 2};
    tbl[3] = '{1, '{63, 0},  '{63, 0}, '{1, 0}, 1'b1, 63, 1, 3};
    tbl[4] = '{2, '{10, 2},  '{7, 1},  '{0, 1}, 1'b1, 2,  1, 5};
    tbl[5] = '{2, '{40, 40}, '{9, 50}, '{0, 1}, 1'b1, 40, 1, 5};

    rst = 1'b1;
    start = 1'b0;
    clear_faults();
    repeat (3) @(negedge clk);
    check("reset_status", {59'd0, busy, done, fail, bif.A_BIST_EN, bif.A_BIST_MEN}, 64'd0);
    check("reset_diag", {fail_addr, fail_elem, fail_cnt}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed fault table; each run after the first also restarts from FINISH.
    for (int t = 0; t < 6; t++) begin
      clear_faults();
      for (int f = 0; f < tbl[t].nf; f++) add_fault(tbl[t].fa[f], tbl[t].fb[f], tbl[t].f1[f]);
      run_one((t == 0) ? 100 : -1, tbl[t].e_fail, tbl[t].e_addr, tbl[t].e_elem, tbl[t].e_cnt);
    end

    // Reset at cycle 300 of a faulty run, then a clean full rerun.
    clear_faults();
    add_fault(5, 3, 1'b1);
    start = 1'b1;
    cyc = 0;
    while (cyc < 300) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
    end
    check("fail_before_reset", fail, 1);
    rst = 1'b1;
    @(negedge clk);
    check("midrun_reset_ctl", {57'd0, busy, done, fail, bif.A_BIST_EN, bif.A_BIST_MEN, bif.A_BIST_WEN, bif.A_BIST_REN}, 64'd0);
    check("midrun_reset_bus", {58'd0, bif.A_BIST_ADDR} | bif.A_BIST_DIN | bif.A_BIST_BM, 64'd0);
    rst = 1'b0;
    clear_faults();
    run_one(-1, 1'b0, 0, 0, 0);

    // Random stuck-at faults plus an ignored mid-run START, checked against the reference.
    for (int r = 0; r < 4; r++) begin
      clear_faults();
      nf = $urandom_range(0, 3);
      for (int f = 0; f < nf; f++)
        add_fault($urandom_range(0, WORDS - 1), $urandom_range(0, DATA_W - 1), 1'($urandom_range(0, 1)));
      xs = $urandom_range(1, NOPS - 1);
      build_model();
      run_one(xs, m_fail, m_faddr, m_felem, m_fcnt);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
